// File: rtl/vga_frame_grabber_if.sv
// ---------------------------------------------------------------------------
// vga_frame_grabber_if
// Pixel stream leaving the frame grabber: one BGR word per beat, with
// start-of-frame and end-of-line markers, valid/ready handshake.
//   pix_data  : {B,G,R} pixel word (DATA_W = 3 * colour width)
//   pix_sof   : first pixel of a frame
//   pix_eol   : last kept pixel of a line
//   pix_valid : head word present
//   pix_ready : consumer takes the head word this cycle
// master = grabber side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vga_frame_grabber_if #(
  parameter int DATA_W = 24
) ();
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output pix_data, pix_sof, pix_eol, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_sof, pix_eol, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/vga_frame_grabber.sv
// ---------------------------------------------------------------------------
// vga_frame_grabber
// Taps the VGA output (RGB, blank, vsync) on the pixel clock and, on request,
// captures one or more whole frames starting at the next complete vsync
// pulse. Active pixels are optionally decimated in both axes, tagged with
// frame/line markers and queued in a small FIFO drained over a valid/ready
// stream.
//
// Ports:
//   CLOCK_25, Reset        : pixel clock, synchronous active-high reset
//   VGA_R/G/B, VGA_BLANK_N : pixel colour and active-video flag
//   VGA_VS                 : vertical sync, active low
//   capture_req/num_frames : start pulse and number of frames to take
//   pix (master)           : output pixel stream {B,G,R} + sof/eol
//   busy                   : engine not idle
//   frame_done/frame_err   : per-frame pulse, err marks an aborted frame
//   overflow               : sticky, a kept pixel was dropped on full FIFO
//
// Optional feature, macro VGA_GRAB_CSUM_EN:
//   adds frame_csum[31:0], the 32-bit wrapping sum of all kept pixel words
//   of the last completed frame (dropped pixels included).
// ---------------------------------------------------------------------------
module vga_frame_grabber #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DECIM      = 1
) (
  input  logic                CLOCK_25,
  input  logic                Reset,
  input  logic [COLOR_W-1:0]  VGA_R,
  input  logic [COLOR_W-1:0]  VGA_G,
  input  logic [COLOR_W-1:0]  VGA_B,
  input  logic                VGA_BLANK_N,
  input  logic                VGA_VS,
  input  logic                capture_req,
  input  logic [7:0]          num_frames,
  vga_frame_grabber_if.master pix,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err,
  output logic                overflow
`ifdef VGA_GRAB_CSUM_EN
  ,
  output logic [31:0]         frame_csum
`endif
);

  localparam int PIX_W  = 3 * COLOR_W;
  localparam int ENT_W  = PIX_W + 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0]  COL_EOL   = COL_W'(H_ACTIVE - DECIM);
  localparam logic [COL_W-1:0]  COL_MASK  = COL_W'(DECIM - 1);
  localparam logic [LINE_W-1:0] LINE_MASK = LINE_W'(DECIM - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          frames_left_q, frames_left_d;
  logic                seen_fall_q, seen_fall_d;   // vsync fall seen while armed
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                vs_q, blank_q;              // previous-cycle sync copies
  logic                stg_vld_q, stg_vld_d;       // sampled pixel awaiting FIFO write
  logic [ENT_W-1:0]    stg_ent_q, stg_ent_d;       // {sof, eol, B, G, R}
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
`ifdef VGA_GRAB_CSUM_EN
  logic [31:0]         csum_acc_q, csum_acc_d, csum_q, csum_d;
`endif

  logic vs_fall_s, vs_rise_s, blank_fall_s, frame_end_s, abort_s;
  logic keep_s, full_s, push_s, pop_s;

  // Next-state logic: sync edge detection, capture FSM, counters and FIFO pointers.
  always_comb begin
    vs_fall_s    = vs_q & ~VGA_VS;
    vs_rise_s    = ~vs_q & VGA_VS;
    blank_fall_s = blank_q & ~VGA_BLANK_N;
    frame_end_s  = blank_fall_s && (line_q == LINE_LAST);
    // a normal frame end wins over a coincident vsync fall
    abort_s      = vs_fall_s && !frame_end_s;
    keep_s       = VGA_BLANK_N && (col_q < COL_MAX) &&
                   ((col_q & COL_MASK) == {COL_W{1'b0}}) &&
                   ((line_q & LINE_MASK) == {LINE_W{1'b0}});
    // room is judged before any same-cycle pop
    full_s       = (cnt_q == CNT_FULL);
    push_s       = stg_vld_q && !full_s;
    pop_s        = valid_q && pix.pix_ready;

    state_d       = state_q;
    frames_left_d = frames_left_q;
    seen_fall_d   = seen_fall_q;
    col_d         = col_q;
    line_d        = line_q;
    stg_vld_d     = 1'b0;
    stg_ent_d     = stg_ent_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    ovf_d         = ovf_q | (stg_vld_q & full_s);
`ifdef VGA_GRAB_CSUM_EN
    csum_acc_d    = csum_acc_q;
    csum_d        = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (capture_req && (num_frames != 8'd0)) begin
          state_d       = S_ARMED;
          frames_left_d = num_frames;
          seen_fall_d   = 1'b0;
          ovf_d         = stg_vld_q & full_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        // capture starts at the end of a complete vsync pulse
        if (seen_fall_q && vs_rise_s) begin
          state_d = S_CAPTURE;
          col_d   = {COL_W{1'b0}};
          line_d  = {LINE_W{1'b0}};
`ifdef VGA_GRAB_CSUM_EN
          csum_acc_d = 32'd0;
`endif
        end else if (vs_fall_s) begin
          seen_fall_d = 1'b1;
        end else begin
          seen_fall_d = seen_fall_q;
        end
      end
      S_CAPTURE: begin
        if (blank_fall_s) begin
          line_d = line_q + LINE_W'(1);
          col_d  = {COL_W{1'b0}};
        end else if (VGA_BLANK_N) begin
          col_d = (col_q < COL_MAX) ? col_q + COL_W'(1) : col_q;
          if (keep_s) begin
            stg_vld_d = 1'b1;
            stg_ent_d = {(col_q == {COL_W{1'b0}}) && (line_q == {LINE_W{1'b0}}),
                         (col_q == COL_EOL), VGA_B, VGA_G, VGA_R};
`ifdef VGA_GRAB_CSUM_EN
            csum_acc_d = csum_acc_q + 32'({VGA_B, VGA_G, VGA_R});
`endif
          end else begin
            stg_vld_d = 1'b0;
          end
        end else begin
          col_d = col_q;
        end

        if (frame_end_s || abort_s) begin
          done_d        = 1'b1;
          err_d         = abort_s;
          frames_left_d = frames_left_q - 8'd1;
`ifdef VGA_GRAB_CSUM_EN
          if (frame_end_s) begin
            csum_d = csum_acc_q;
          end else begin
            csum_d = csum_q;
          end
`endif
          if (frames_left_q == 8'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_ARMED;
            // the aborting vsync low already counts as the falling edge
            seen_fall_d = abort_s;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    valid_d  = (cnt_d != {CNT_W{1'b0}});
    busy_d   = (state_d != S_IDLE);
  end

  // State, counter, FIFO and output registers with synchronous reset.
  always_ff @(posedge CLOCK_25) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      frames_left_q <= 8'd0;
      seen_fall_q   <= 1'b0;
      col_q         <= {COL_W{1'b0}};
      line_q        <= {LINE_W{1'b0}};
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      stg_vld_q     <= 1'b0;
      stg_ent_q     <= {ENT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
`ifdef VGA_GRAB_CSUM_EN
      csum_acc_q    <= 32'd0;
      csum_q        <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      frames_left_q <= frames_left_d;
      seen_fall_q   <= seen_fall_d;
      col_q         <= col_d;
      line_q        <= line_d;
      vs_q          <= VGA_VS;
      blank_q       <= VGA_BLANK_N;
      stg_vld_q     <= stg_vld_d;
      stg_ent_q     <= stg_ent_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= stg_ent_q;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
`ifdef VGA_GRAB_CSUM_EN
      csum_acc_q    <= csum_acc_d;
      csum_q        <= csum_d;
`endif
    end
  end

  assign pix.pix_data  = mem_q[rd_ptr_q][PIX_W-1:0];
  assign pix.pix_sof   = mem_q[rd_ptr_q][ENT_W-1];
  assign pix.pix_eol   = mem_q[rd_ptr_q][ENT_W-2];
  assign pix.pix_valid = valid_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign overflow      = ovf_q;
`ifdef VGA_GRAB_CSUM_EN
  assign frame_csum    = csum_q;
`endif

endmodule

// File: tb/tb_vga_frame_grabber.sv
`timescale 1ns/1ps
// Randomized-pixel bench for vga_frame_grabber. A VGA timing generator drives
// small frames; a frame-level reference (which frames are captured, which
// words they yield) fills an expected-word queue that a stream monitor
// compares against every accepted output word.
module tb_vga_frame_grabber;
  localparam int H     = 16;
  localparam int V     = 8;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int D     = 2;
  localparam int HBL   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] r, g, b;
  logic          blank_n, vs, req;
  logic [7:0]    nfr;
  logic          busy, fdone, ferr, ovf;
`ifdef VGA_GRAB_CSUM_EN
  logic [31:0]   csum;
`endif

  always #5 clk = ~clk;

  vga_frame_grabber_if #(.DATA_W(3*CW)) pif ();

  vga_frame_grabber #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(CW), .FIFO_DEPTH(DEPTH), .DECIM(D)
  ) dut (
    .CLOCK_25(clk), .Reset(rst),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_BLANK_N(blank_n), .VGA_VS(vs),
    .capture_req(req), .num_frames(nfr),
    .pix(pif),
    .busy(busy), .frame_done(fdone), .frame_err(ferr), .overflow(ovf)
`ifdef VGA_GRAB_CSUM_EN
    , .frame_csum(csum)
`endif
  );

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [3*CW-1:0] data;
  } word_t;

  word_t       exp_q[$];
  word_t       mon_w;
  int          n_cmp = 0, n_err = 0;
  int          frames_left = 0;
  bit          cur_cap = 1'b0, pend_abort = 1'b0, bp_mode = 1'b0, m_ovf = 1'b0;
  int          bp_kept = 0;
  int          exp_done = 0, exp_err = 0, got_done = 0, got_err = 0;
  logic [31:0] m_sum = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (fdone === 1'b1) got_done++;
    if (ferr === 1'b1) got_err++;
    if (pif.pix_valid && pif.pix_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_word", pif.pix_valid, 1'b0);
      end else begin
        mon_w = exp_q.pop_front();
        check_eq("pix_data", pif.pix_data, mon_w.data);
        check_eq("pix_sof", pif.pix_sof, mon_w.sof);
        check_eq("pix_eol", pif.pix_eol, mon_w.eol);
      end
    end
  end

  task automatic request(input int n);
    req = 1'b1;
    nfr = 8'(n);
    tick();
    req = 1'b0;
    if (frames_left == 0 && n != 0) begin
      frames_left = n;
      m_ovf = 1'b0;
    end
    check_eq("busy_after_req", busy, frames_left > 0);
    check_eq("ovf_after_req", ovf, m_ovf);
  endtask

  task automatic drive_line(input int l);
    word_t w;
    for (int c = 0; c < H; c++) begin
      blank_n = 1'b1;
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      if (cur_cap && (l % D == 0) && (c % D == 0)) begin
        w.data = {b, g, r};
        w.sof  = (l == 0 && c == 0);
        w.eol  = (c == H - D);
        m_sum  = m_sum + 32'({b, g, r});
        if (!bp_mode || bp_kept < DEPTH) exp_q.push_back(w);
        if (bp_mode) begin
          bp_kept++;
          if (bp_kept > DEPTH) m_ovf = 1'b1;
        end
      end
      tick();
    end
    blank_n = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0;
    tick();  // this edge samples the blank falling edge
    if (cur_cap && l == V - 1) begin
      frames_left--;
      exp_done++;
      cur_cap = 1'b0;
      check_eq("frame_done", fdone, 1'b1);
      check_eq("frame_err_full", ferr, 1'b0);
`ifdef VGA_GRAB_CSUM_EN
      tick();
      check_eq("frame_csum", csum, m_sum);
`endif
    end else begin
      check_eq("no_done", fdone, 1'b0);
    end
    for (int i = 1; i < HBL; i++) tick();
    check_eq("overflow", ovf, m_ovf);
  endtask

  task automatic drive_frame(input int nlines, input int rst_line);
    blank_n = 1'b0;
    vs = 1'b0;
    tick();  // edge samples the vsync fall
    if (pend_abort) begin
      pend_abort = 1'b0;
      frames_left--;
      exp_done++;
      exp_err++;
      check_eq("abort_done", fdone, 1'b1);
      check_eq("abort_err", ferr, 1'b1);
    end else begin
      check_eq("no_abort_err", ferr, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick();
    vs = 1'b1;
    cur_cap = (frames_left > 0);
    if (cur_cap) begin
      m_sum = 32'd0;
      bp_kept = 0;
    end
    tick();
    check_eq("busy_frame", busy, frames_left > 0);
    for (int i = 0; i < 4; i++) tick();
    for (int l = 0; l < nlines; l++) begin
      drive_line(l);
      if (l == rst_line) begin
        rst = 1'b1;
        tick();
        check_eq("rst_valid", pif.pix_valid, 1'b0);
        check_eq("rst_sof", pif.pix_sof, 1'b0);
        check_eq("rst_eol", pif.pix_eol, 1'b0);
        check_eq("rst_data", pif.pix_data, 24'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", fdone, 1'b0);
        check_eq("rst_err", ferr, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        frames_left = 0;
        cur_cap = 1'b0;
        m_ovf = 1'b0;
      end
    end
    pend_abort = cur_cap && (nlines < V);
    cur_cap = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("busy_end", busy, frames_left > 0);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b1; blank_n = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0;
    req = 1'b0; nfr = 8'd0;
    pif.pix_ready = 1'b1;
    tick();
    tick();
    check_eq("reset_valid", pif.pix_valid, 1'b0);
    check_eq("reset_data", pif.pix_data, 24'd0);
    check_eq("reset_sof", pif.pix_sof, 1'b0);
    check_eq("reset_eol", pif.pix_eol, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", fdone, 1'b0);
    check_eq("reset_ovf", ovf, 1'b0);
    rst = 1'b0;
    tick();

    // free-running frame with no capture, then a zero-frame request
    drive_frame(V, -1);
    request(0);

    // single frame
    request(1);
    drive_frame(V, -1);

    // burst of three with an ignored request in between
    request(3);
    drive_frame(V, -1);
    request(5);
    drive_frame(V, -1);
    drive_frame(V, -1);

    // short (aborted) frame followed by a full one
    request(2);
    drive_frame(5, -1);
    drive_frame(V, -1);

    // backpressure: nothing drained during the frame
    pif.pix_ready = 1'b0;
    bp_mode = 1'b1;
    request(1);
    drive_frame(V, -1);
    check_eq("bp_valid", pif.pix_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_hold_data", pif.pix_data, exp_q[0].data);
      check_eq("bp_hold_sof", pif.pix_sof, exp_q[0].sof);
      tick();
    end
    pif.pix_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    tick();
    check_eq("bp_drained", pif.pix_valid, 1'b0);
    check_eq("bp_left", exp_q.size(), 0);
    bp_mode = 1'b0;

    // reset in the middle of a captured frame, then a clean capture
    request(1);
    drive_frame(V, 4);
    request(1);
    drive_frame(V, -1);
    tick();

    check_eq("done_total", got_done, exp_done);
    check_eq("err_total", got_err, exp_err);
    check_eq("final_valid", pif.pix_valid, 1'b0);
    check_eq("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
